dmem_arbiter: RTL and testbench

- Shares the single-port data SRAM between the pipeline load/store path and an auxiliary master (debug/DMA port).
- Sits between the EX-stage memory request outputs and the data SRAM interface. Read data is still consumed by the MEM stage one cycle after issue.
- The CPU has priority by default. A starvation counter forces aux grants and raises a stall request to the stall controller, which drives the stall bus.

---
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data SRAM between the pipeline
// load/store path (priority) and an auxiliary debug/DMA master. A starvation
// counter forces short aux bursts and stalls the CPU while they run.
// Optional macro DMEM_ARB_PERF_EN adds conflict/stall performance counters.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_LEN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stallreq_dmem,
  input  logic        aux_req,
  input  logic [3:0]  aux_wen,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int unsigned BURST_W = $clog2(BURST_LEN + 1);
  localparam logic [WAIT_W-1:0]  WAIT_SAT   = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0]  WAIT_TRIG  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);

  typedef enum logic {S_CPU, S_AUX} state_t;
  typedef enum logic {OWN_CPU, OWN_AUX} owner_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  owner_t              last_owner_q, last_owner_d;
  logic                aux_pending_rd_q, aux_pending_rd_d;

  logic                sel_cpu;
  logic                sel_aux;

  // Arbitration: forced aux burst in S_AUX, otherwise CPU-priority with starvation tracking
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    sel_cpu       = 1'b0;
    sel_aux       = 1'b0;
    aux_gnt       = 1'b0;
    stallreq_dmem = 1'b0;
    if (state_q == S_AUX && aux_req) begin
      sel_aux       = 1'b1;
      aux_gnt       = 1'b1;
      stallreq_dmem = cpu_en;
      if (burst_cnt_q == BURST_LAST) begin
        state_d     = S_CPU;
        burst_cnt_d = '0;
        wait_cnt_d  = '0;
      end else begin
        burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end
    end else begin
      // An S_AUX cycle without aux_req falls back to normal arbitration.
      state_d     = S_CPU;
      burst_cnt_d = '0;
      if (cpu_en) begin
        sel_cpu = 1'b1;
        if (aux_req) begin
          if (wait_cnt_q != WAIT_SAT) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
          if (wait_cnt_q == WAIT_TRIG) begin
            state_d = S_AUX;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end else begin
        wait_cnt_d = '0;
        if (aux_req) begin
          sel_aux = 1'b1;
          aux_gnt = 1'b1;
        end
      end
    end
  end

  // SRAM port mux and read-return bookkeeping
  always_comb begin
    data_sram_en     = 1'b0;
    data_sram_wen    = '0;
    data_sram_addr   = '0;
    data_sram_wdata  = '0;
    last_owner_d     = last_owner_q;
    aux_pending_rd_d = 1'b0;
    if (sel_cpu) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = cpu_wen;
      data_sram_addr  = cpu_addr;
      data_sram_wdata = cpu_wdata;
      last_owner_d    = OWN_CPU;
    end else if (sel_aux) begin
      data_sram_en     = 1'b1;
      data_sram_wen    = aux_wen;
      data_sram_addr   = aux_addr;
      data_sram_wdata  = aux_wdata;
      last_owner_d     = OWN_AUX;
      aux_pending_rd_d = (aux_wen == 4'b0000);
    end
  end

  // Read data steering one cycle after issue
  always_comb begin
    aux_rvalid = aux_pending_rd_q;
    aux_rdata  = aux_pending_rd_q ? data_sram_rdata : '0;
    cpu_rdata  = (last_owner_q == OWN_CPU) ? data_sram_rdata : '0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_CPU;
      wait_cnt_q       <= '0;
      burst_cnt_q      <= '0;
      last_owner_q     <= OWN_CPU;
      aux_pending_rd_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      burst_cnt_q      <= burst_cnt_d;
      last_owner_q     <= last_owner_d;
      aux_pending_rd_q <= aux_pending_rd_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Wrap-around performance counters
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (cpu_en && aux_req) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
    if (stallreq_dmem) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign perf_conflict_cnt = conflict_cnt_q;
  assign perf_stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver applies stimulus and pushes the
// expected per-cycle response from a behavioural model; a monitor pops and
// compares on the falling edge.
module tb_dmem_arbiter;

  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned BURST_LEN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stallreq_dmem;
  logic        aux_req;
  logic [3:0]  aux_wen;
  logic [31:0] aux_addr;
  logic [31:0] aux_wdata;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [31:0] aux_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  dmem_arbiter #(
    .MAX_WAIT  (MAX_WAIT),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_en          (cpu_en),
    .cpu_wen         (cpu_wen),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .stallreq_dmem   (stallreq_dmem),
    .aux_req         (aux_req),
    .aux_wen         (aux_wen),
    .aux_addr        (aux_addr),
    .aux_wdata       (aux_wdata),
    .aux_gnt         (aux_gnt),
    .aux_rvalid      (aux_rvalid),
    .aux_rdata       (aux_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        gnt;
    logic        stall;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata_in;
    logic        own_cpu;
    logic [31:0] pc;
    logic [31:0] ps;
  } exp_t;

  exp_t exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: consecutive denials and remaining forced grants
  int unsigned denials     = 0;
  int unsigned forced_left = 0;
  bit          m_last_cpu  = 1'b1;
  bit          m_aux_rd    = 1'b0;
  logic [31:0] m_conf      = '0;
  logic [31:0] m_stall     = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit c_en, input logic [3:0] c_wen,
                      input logic [31:0] c_addr, input logic [31:0] c_wdata,
                      input bit a_req, input logic [3:0] a_wen,
                      input logic [31:0] a_addr, input logic [31:0] a_wdata,
                      input logic [31:0] rd);
    exp_t e;
    bit use_cpu;
    bit use_aux;
    @(posedge clk);
    #1;
    rst = r; cpu_en = c_en; cpu_wen = c_wen; cpu_addr = c_addr; cpu_wdata = c_wdata;
    aux_req = a_req; aux_wen = a_wen; aux_addr = a_addr; aux_wdata = a_wdata;
    data_sram_rdata = rd;

    use_cpu = 1'b0;
    use_aux = 1'b0;
    e.chk = !r;
    e.stall = 1'b0;
    e.rvalid = m_aux_rd;
    e.own_cpu = m_last_cpu;
    e.rdata_in = rd;
    e.pc = m_conf;
    e.ps = m_stall;
    if (forced_left > 0 && a_req) begin
      use_aux = 1'b1;
      e.stall = c_en;
      forced_left--;
    end else begin
      forced_left = 0;
      if (c_en) begin
        use_cpu = 1'b1;
        if (a_req) begin
          denials++;
          if (denials == MAX_WAIT) begin
            forced_left = BURST_LEN;
            denials = 0;
          end
        end else begin
          denials = 0;
        end
      end else begin
        denials = 0;
        use_aux = a_req;
      end
    end
    e.gnt = use_aux;
    e.en = use_cpu | use_aux;
    e.wen = use_cpu ? c_wen : (use_aux ? a_wen : 4'h0);
    e.addr = use_cpu ? c_addr : (use_aux ? a_addr : 32'h0);
    e.wdata = use_cpu ? c_wdata : (use_aux ? a_wdata : 32'h0);
    exp_q.push_back(e);

    if (r) begin
      denials = 0; forced_left = 0; m_last_cpu = 1'b1; m_aux_rd = 1'b0;
      m_conf = '0; m_stall = '0;
    end else begin
      if (use_cpu) m_last_cpu = 1'b1;
      else if (use_aux) m_last_cpu = 1'b0;
      m_aux_rd = use_aux && (a_wen == 4'h0);
      if (c_en && a_req) m_conf = m_conf + 32'd1;
      if (e.stall) m_stall = m_stall + 32'd1;
    end
  endtask

  task automatic idle(input bit r, input logic [31:0] rd);
    step(r, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, rd);
  endtask

  task automatic conflict(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 4'h0, 32'h200 + 32'(i * 4), 32'h0, 1'b1, 4'h0,
           32'h80 + 32'(i * 4), 32'h0, $urandom);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          cmp("aux_gnt", 32'(aux_gnt), 32'(e.gnt));
          cmp("stallreq_dmem", 32'(stallreq_dmem), 32'(e.stall));
          cmp("sram_en", 32'(data_sram_en), 32'(e.en));
          cmp("sram_wen", 32'(data_sram_wen), 32'(e.wen));
          cmp("sram_addr", data_sram_addr, e.addr);
          cmp("sram_wdata", data_sram_wdata, e.wdata);
          cmp("aux_rvalid", 32'(aux_rvalid), 32'(e.rvalid));
          if (e.rvalid) cmp("aux_rdata", aux_rdata, e.rdata_in);
          cmp("cpu_rdata", cpu_rdata, e.own_cpu ? e.rdata_in : 32'h0);
`ifdef DMEM_ARB_PERF_EN
          cmp("perf_conflict", perf_conflict_cnt, e.pc);
          cmp("perf_stall", perf_stall_cnt, e.ps);
`endif
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 1'b0; aux_wen = '0; aux_addr = '0; aux_wdata = '0; data_sram_rdata = '0;

    // Reset, then all-idle cycles: every output zero
    idle(1'b1, 32'h0);
    idle(1'b1, 32'h0);
    idle(1'b0, 32'h0);
    idle(1'b0, 32'h0);

    // CPU-only read, data returned next cycle
    step(1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    idle(1'b0, 32'hDEADBEEF);

    // Aux write in an idle slot: no read return
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h40, 32'h12345678, 32'h0);
    idle(1'b0, 32'h5A5A5A5A);

    // Starvation: 4 denials, 2 forced aux reads, then CPU again
    idle(1'b1, 32'h0);
    conflict(7);
    idle(1'b0, 32'hCAFEF00D);

    // Early burst exit after one forced grant
    idle(1'b1, 32'h0);
    conflict(5);
    step(1'b0, 1'b1, 4'h3, 32'h300, 32'h11223344, 1'b0, 4'h0, 32'h0, 32'h0, 32'hAAAA0001);
    idle(1'b0, 32'hAAAA0002);

    // Reset in the first forced cycle
    idle(1'b1, 32'h0);
    conflict(4);
    step(1'b1, 1'b1, 4'h0, 32'h400, 32'h0, 1'b1, 4'h0, 32'h44, 32'h0, 32'h1);
    conflict(2);
    idle(1'b0, 32'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 65),
           ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
           $urandom, $urandom,
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
           $urandom, $urandom, $urandom);
    end
    idle(1'b0, 32'h0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
